// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES controller responder.
//   NES_BITS      : number of serial bits in one poll
//   BTN_A..BTN_RIGHT : bit positions of each button in the button byte
//   pad_state_e   : responder poll state
package nes_pad_pkg;

  localparam int unsigned NES_BITS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pad_state_e;

endpackage

// File: rtl/nes_pad_input_filter.sv
// Synchronizer + glitch filter for one asynchronous console line.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_async      : raw asynchronous input
//   o_level      : filtered level
//   o_rise       : one-cycle strobe, coincident with o_level going 1
//   o_fall       : one-cycle strobe, coincident with o_level going 0
// A new level is accepted only after GLITCH_CYCLES consecutive synchronized
// samples differ from the current filtered level; the accepted edge appears
// 2+GLITCH_CYCLES cycles after a clean raw edge.
module nes_pad_input_filter #(
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic          fall_q,  fall_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample matching the current level restarts the run count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(GLITCH_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: answers console latch/pulse polls with the
// current button state, serially, pressed = 0 on the line.
//   i_clk, i_rst  : system clock, synchronous active-high reset
//   i_latch       : console latch (async, active-high)
//   i_pulse       : console data clock (async, bit advances on rise)
//   i_buttons     : pressed=1; A,B,Select,Start,Up,Down,Left,Right (bit0..7)
//   i_turbo       : turbo enable for A (bit0) and B (bit1)
//   o_data        : serial line to console
//   o_poll_done   : one-cycle strobe when the 8th bit is shifted out
//   o_bit_idx     : index of the bit currently on o_data (0..8)
// Build option: define NES_PAD_TURBO_EN to build the turbo phase logic;
// otherwise i_turbo is ignored and effective buttons equal i_buttons.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned TURBO_FRAMES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_latch,
  input  logic       i_pulse,
  input  logic [7:0] i_buttons,
  input  logic [1:0] i_turbo,
  output logic       o_data,
  output logic       o_poll_done,
  output logic [3:0] o_bit_idx
);

  logic latch_level, latch_rise, latch_fall;
  logic pulse_level, pulse_rise, pulse_fall;

  nes_pad_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_latch_filter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_latch),
    .o_level (latch_level),
    .o_rise  (latch_rise),
    .o_fall  (latch_fall)
  );

  nes_pad_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_pulse_filter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pulse),
    .o_level (pulse_level),
    .o_rise  (pulse_rise),
    .o_fall  (pulse_fall)
  );

  logic [7:0] eff_buttons;
  logic       unused_sigs;

`ifdef NES_PAD_TURBO_EN
  localparam int unsigned TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

  logic [TW-1:0] turbo_cnt_q, turbo_cnt_d;
  logic          phase_q,     phase_d;

  always_comb begin
    turbo_cnt_d = turbo_cnt_q;
    phase_d     = phase_q;
    if (latch_fall) begin
      if (turbo_cnt_q == TW'(TURBO_FRAMES - 1)) begin
        turbo_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + 1'b1;
      end
    end
    eff_buttons        = i_buttons;
    eff_buttons[BTN_A] = i_buttons[BTN_A] & (~i_turbo[0] | phase_q);
    eff_buttons[BTN_B] = i_buttons[BTN_B] & (~i_turbo[1] | phase_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      turbo_cnt_q <= turbo_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign unused_sigs = ^{latch_rise, pulse_level, pulse_fall};
`else
  assign eff_buttons = i_buttons;
  assign unused_sigs = ^{latch_rise, latch_fall, pulse_level, pulse_fall,
                         i_turbo, TURBO_FRAMES[0]};
`endif

  pad_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic       data_q, data_d;
  logic       poll_done_q, poll_done_d;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      data_q      <= 1'b1;
      poll_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      poll_done_q <= poll_done_d;
    end
  end

  // Next-state logic: a high latch wins over everything, including a
  // simultaneous pulse edge in SHIFT.
  always_comb begin
    state_d = state_q;
    if (latch_level) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        // The filtered level drops in the same cycle as the fall strobe,
        // so testing the level keeps LOAD from ever sticking.
        ST_LOAD:  state_d = ST_SHIFT;
        ST_SHIFT: if (pulse_rise && (bit_idx_q == 4'(NES_BITS - 1))) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Output / datapath logic (registered outputs)
  always_comb begin
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    data_d      = data_q;
    poll_done_d = 1'b0;
    if (latch_level) begin
      shreg_d   = eff_buttons;
      data_d    = ~eff_buttons[0];
      bit_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_d    = 1'b1;
          bit_idx_d = '0;
        end
        ST_LOAD: begin
          // Latch has fallen: keep the last loaded value frozen.
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'(NES_BITS - 1)) begin
              data_d      = 1'b0;
              poll_done_d = 1'b1;
            end else begin
              data_d = ~shreg_q[1];
            end
          end
        end
        default: begin
          data_d    = 1'b0;
          bit_idx_d = 4'(NES_BITS);
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_poll_done = poll_done_q;
  assign o_bit_idx   = bit_idx_q;

endmodule
